// File: rtl/vga_sync_generator_pkg.sv
// Shared definitions for the VGA path.
// - Default 640x480 @ 60 Hz timing constants (25 MHz pixel clock).
// - Colour codes shared with the colour stage.
// - Bundle type for the delayed sync signals and its inactive (reset) value.
package vga_sync_generator_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int unsigned DefHVisible = 640;
  localparam int unsigned DefHFront   = 16;
  localparam int unsigned DefHSync    = 96;
  localparam int unsigned DefHBack    = 48;

  // Vertical timing, in lines.
  localparam int unsigned DefVVisible = 480;
  localparam int unsigned DefVFront   = 10;
  localparam int unsigned DefVSync    = 2;
  localparam int unsigned DefVBack    = 33;

  localparam int unsigned DefCoordBit = 10;

  // 3-bit RGB colour codes used by the colour stage.
  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;
  localparam logic [2:0] RED   = 3'b100;
  localparam logic [2:0] WHITE = 3'b111;

  // Signals that travel through the sync delay line together.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
  } sync_bits_t;

  // Syncs are active-low, so idle is high; blanking is active while blank_n is low.
  localparam sync_bits_t SyncIdle = '{hsync: 1'b1, vsync: 1'b1, blank_n: 1'b0};

  // Total period from the four timing segments.
  function automatic int unsigned timing_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_sync_generator_if.sv
// Output bundle of the VGA sync generator.
// master: driven by vga_sync_generator. slave: colour stage / address logic.
//   display_area  high while the current pixel is visible
//   x_pixel       column of the current pixel (0 outside the visible area)
//   y_pixel       line of the current pixel (0 outside the visible area)
//   hsync/vsync   active-low syncs, delayed to match the registered RGB
//   blank_n       display_area, delayed like the syncs
//   frame_start   one-clock pulse on the first visible pixel of a frame
//   line_end      one-clock pulse on the last visible pixel of a visible line
interface vga_sync_generator_if #(
  parameter int unsigned COORD_BIT = 10
) ();

  logic                 display_area;
  logic [COORD_BIT-1:0] x_pixel;
  logic [COORD_BIT-1:0] y_pixel;
  logic                 hsync;
  logic                 vsync;
  logic                 blank_n;
  logic                 frame_start;
  logic                 line_end;

  modport master (
    output display_area,
    output x_pixel,
    output y_pixel,
    output hsync,
    output vsync,
    output blank_n,
    output frame_start,
    output line_end
  );

  modport slave (
    input display_area,
    input x_pixel,
    input y_pixel,
    input hsync,
    input vsync,
    input blank_n,
    input frame_start,
    input line_end
  );

endinterface

// File: rtl/vga_sync_generator_sync_delay_line.sv
// Depth-stage register chain with asynchronous active-low reset.
// Every stage resets to ResetVal so the output is inactive immediately on reset.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   d_i     input bundle
//   q_o     d_i delayed by Depth clocks (Depth >= 1)
module vga_sync_generator_sync_delay_line #(
  parameter int unsigned       Width    = 3,
  parameter int unsigned       Depth    = 1,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_d [Depth];
  logic [Width-1:0] stage_q [Depth];

  always_comb begin
    stage_d[0] = d_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= ResetVal;
      end
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/vga_sync_generator.sv
// VGA timing source: horizontal/vertical counters, registered display qualifier,
// pixel coordinates and frame/line pulses, plus active-low syncs and blank_n
// delayed by SYNC_DELAY clocks to line up with the colour stage's registered RGB.
//   clock_25  pixel clock
//   reset     asynchronous active-low reset
//   vga       output bundle (master modport)
// SYNC_DELAY must be 0..3; COORD_BIT must be at least clog2(H_VISIBLE).
module vga_sync_generator
  import vga_sync_generator_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DefHVisible,
  parameter int unsigned H_FRONT    = DefHFront,
  parameter int unsigned H_SYNC     = DefHSync,
  parameter int unsigned H_BACK     = DefHBack,
  parameter int unsigned V_VISIBLE  = DefVVisible,
  parameter int unsigned V_FRONT    = DefVFront,
  parameter int unsigned V_SYNC     = DefVSync,
  parameter int unsigned V_BACK     = DefVBack,
  parameter int unsigned COORD_BIT  = DefCoordBit,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic                 clock_25,
  input  logic                 reset,
  vga_sync_generator_if.master vga
);

  localparam int unsigned HTotal = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);

  localparam int unsigned HSyncStart = H_VISIBLE + H_FRONT;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart = V_VISIBLE + V_FRONT;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;

  typedef logic [HW-1:0]        hcnt_t;
  typedef logic [VW-1:0]        vcnt_t;
  typedef logic [COORD_BIT-1:0] coord_t;

  localparam hcnt_t HLast = hcnt_t'(HTotal - 1);
  localparam vcnt_t VLast = vcnt_t'(VTotal - 1);
  localparam hcnt_t HOne  = hcnt_t'(1);
  localparam vcnt_t VOne  = vcnt_t'(1);

  hcnt_t  h_count_d, h_count_q;
  vcnt_t  v_count_d, v_count_q;

  logic   display_area_d, display_area_q;
  coord_t x_pixel_d, x_pixel_q;
  coord_t y_pixel_d, y_pixel_q;
  logic   frame_start_d, frame_start_q;
  logic   line_end_d, line_end_q;
  logic   hsync_d, hsync_q;
  logic   vsync_d, vsync_q;

  logic       vis;
  logic       h_wrap;
  sync_bits_t sync_s1;
  sync_bits_t sync_dly;

  // Counters and raw decode.
  always_comb begin
    h_wrap    = (h_count_q == HLast);
    h_count_d = h_wrap ? '0 : h_count_q + HOne;
    v_count_d = v_count_q;
    if (h_wrap) begin
      v_count_d = (v_count_q == VLast) ? '0 : v_count_q + VOne;
    end

    vis = (32'(h_count_q) < H_VISIBLE) && (32'(v_count_q) < V_VISIBLE);

    // Stage 1 next-state; comparisons done at 32 bits so a sync end equal to the
    // total period never overflows the counter width.
    display_area_d = vis;
    x_pixel_d      = vis ? coord_t'(h_count_q) : '0;
    y_pixel_d      = vis ? coord_t'(v_count_q) : '0;
    frame_start_d  = (h_count_q == '0) && (v_count_q == '0);
    line_end_d     = vis && (32'(h_count_q) == H_VISIBLE - 1);
    hsync_d        = !((32'(h_count_q) >= HSyncStart) && (32'(h_count_q) < HSyncEnd));
    vsync_d        = !((32'(v_count_q) >= VSyncStart) && (32'(v_count_q) < VSyncEnd));
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      h_count_q      <= '0;
      v_count_q      <= '0;
      display_area_q <= 1'b0;
      x_pixel_q      <= '0;
      y_pixel_q      <= '0;
      frame_start_q  <= 1'b0;
      line_end_q     <= 1'b0;
      hsync_q        <= 1'b1;
      vsync_q        <= 1'b1;
    end else begin
      h_count_q      <= h_count_d;
      v_count_q      <= v_count_d;
      display_area_q <= display_area_d;
      x_pixel_q      <= x_pixel_d;
      y_pixel_q      <= y_pixel_d;
      frame_start_q  <= frame_start_d;
      line_end_q     <= line_end_d;
      hsync_q        <= hsync_d;
      vsync_q        <= vsync_d;
    end
  end

  // blank_n at stage 1 is simply the registered display_area.
  always_comb begin
    sync_s1         = SyncIdle;
    sync_s1.hsync   = hsync_q;
    sync_s1.vsync   = vsync_q;
    sync_s1.blank_n = display_area_q;
  end

  if (SYNC_DELAY == 0) begin : g_no_delay
    assign sync_dly = sync_s1;
  end else begin : g_delay
    vga_sync_generator_sync_delay_line #(
      .Width    ($bits(sync_bits_t)),
      .Depth    (SYNC_DELAY),
      .ResetVal (SyncIdle)
    ) u_sync_delay_line (
      .clk_i  (clock_25),
      .rst_ni (reset),
      .d_i    (sync_s1),
      .q_o    (sync_dly)
    );
  end

  assign vga.display_area = display_area_q;
  assign vga.x_pixel      = x_pixel_q;
  assign vga.y_pixel      = y_pixel_q;
  assign vga.frame_start  = frame_start_q;
  assign vga.line_end     = line_end_q;
  assign vga.hsync        = sync_dly.hsync;
  assign vga.vsync        = sync_dly.vsync;
  assign vga.blank_n      = sync_dly.blank_n;

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
Timing source for the VGA path. Generates the horizontal and vertical counters, active-low hsync/vsync, the display_area qualifier and pixel coordinates consumed by the colour stage and the game/ROM address logic. Default timing is 640x480 at 60 Hz on the 25 MHz pixel clock. The sync outputs carry a configurable extra delay so they line up with the registered RGB produced by the colour stage.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BACK, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
COORD_BIT, 10, width of the x/y coordinate outputs
SYNC_DELAY, 1, extra clocks applied to hsync/vsync/blank_n relative to display_area (0..3)

Ports:
clock_25  input  1  25 MHz pixel clock
reset  input  1  asynchronous, active-low reset
display_area  output  1  high while the current pixel is visible
x_pixel  output  COORD_BIT  column of the current pixel, 0 outside the visible area
y_pixel  output  COORD_BIT  line of the current pixel, 0 outside the visible area
hsync  output  1  horizontal sync, active-low, delayed by SYNC_DELAY
vsync  output  1  vertical sync, active-low, delayed by SYNC_DELAY
blank_n  output  1  DAC blank, equal to display_area delayed by SYNC_DELAY
frame_start  output  1  one-clock pulse on the first visible pixel of each frame
line_end  output  1  one-clock pulse on the last visible pixel of each visible line

Behaviour:
- Reset is asynchronous and active-low on clock_25. While reset is low: h_count=0, v_count=0, display_area=0, x_pixel=0, y_pixel=0, frame_start=0, line_end=0, hsync=1, vsync=1, blank_n=0. All delay-line stages load the same inactive values.
- H_TOTAL = sum of the four H parameters (default 800). V_TOTAL = sum of the four V parameters (default 525).
- h_count increments every clock and wraps from H_TOTAL-1 to 0. v_count increments only when h_count wraps, and wraps from V_TOTAL-1 to 0 on that same clock.
- Raw decode from the counters, all combinational:
  - vis = (h_count < H_VISIBLE) && (v_count < V_VISIBLE)
  - hs_raw is low for H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC
  - vs_raw is low for V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC; it is a function of v_count only, so it changes at line boundaries.
- Stage 1, registered, latency 1 from the counters:
  - display_area <= vis
  - x_pixel <= vis ? h_count : 0
  - y_pixel <= vis ? v_count : 0
  - frame_start <= (h_count==0 && v_count==0)
  - line_end <= vis && h_count==H_VISIBLE-1
- hsync, vsync and blank_n are stage 1 values passed through a SYNC_DELAY-deep shift register. With SYNC_DELAY=0 they leave stage 1 directly. With the default of 1 they are aligned with the registered RGB of the colour stage.
- First clock after reset release: counters start at 0, so frame_start and display_area rise together one clock later, with x_pixel=0 and y_pixel=0.
- Counter widths are clog2 of H_TOTAL and of V_TOTAL. x_pixel and y_pixel are truncated to COORD_BIT; COORD_BIT must be at least clog2(H_VISIBLE).
- Reset asserted mid-frame clears all state immediately. No partial sync pulse is held; the outputs go to their inactive values asynchronously.

Decomposition:
- Shared package/include: the default 640x480 timing constants, and the colour codes already used by the colour stage (BLACK, GREEN, RED, WHITE) so both blocks draw from one definition.
- One natural sub-module, sync_delay_line: a parameterised N-stage register chain with asynchronous active-low reset and a per-bit reset value. It is instantiated once for the bundle {hsync, vsync, blank_n}.

Test Plan:
1. Reset low for 5 clocks then released -> hsync=1, vsync=1, display_area=0, blank_n=0 during reset. On clock 1 after release, frame_start=1, display_area=1, x_pixel=0, y_pixel=0.
2. Run one full line -> display_area high for exactly 640 consecutive clocks. line_end pulses once, with x_pixel=639. hsync goes low 657 clocks after display_area rises (656 plus SYNC_DELAY 1) and stays low 96 clocks. The line period is 800 clocks.
3. Run one full frame -> exactly 800*525=420000 clocks between frame_start pulses. vsync is low for 1600 clocks starting at line 490. display_area is never high for y >= 480.
4. Set SYNC_DELAY=0, then SYNC_DELAY=2 -> the hsync falling edge relative to the display_area rise moves to 656 and 658 clocks respectively. blank_n always equals display_area delayed by SYNC_DELAY.
5. Assert reset at line 200, pixel 300 -> all outputs go inactive before the next edge. After release, frame_start recurs after 1 clock, not at the old frame position.
6. Override the parameters to H=8/1/2/1 and V=4/1/1/1 -> line period 12 and frame period 84. Check the wrap of h_count and v_count on the same clock at (11,6).
